cb_config_writer: RTL and testbench

- Frame-programming master that drives the memory-bank configuration port (enable / address / data_in) of connection blocks and switch blocks.
- Accepts a byte-stream bitstream over a valid/ready handshake.
- Unpacks each packet into per-bit configuration writes. Each write is presented with a one-cycle setup before its enable strobe, so the block's internal decoder and SRAM latches see stable address and data.
- Sits between the bitstream loader (upstream) and one tile's configuration port.

---
 rtl/cb_config_pkg.sv | 17 +
 rtl/cb_config_writer.sv | 140 ++++++++++++++
 tb/tb_cb_config_writer.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cb_config_pkg.sv
// Shared state type and framing constants for the tile configuration writer.
package cb_config_pkg;

    localparam int unsigned HDR_BYTES = 2;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned IDX_W     = $clog2(BYTE_W);

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StLoad,
        StSetup,
        StStrobe,
        StDone
    } cfg_state_e;

endpackage

// File: rtl/cb_config_writer.sv
// Unpacks {start address, bit count, data bytes} packets into one-bit writes on a tile's
// memory-bank configuration port, with a setup cycle ahead of every enable strobe.
module cb_config_writer
    import cb_config_pkg::*;
#(
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned MAX_BITS = 255
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              enable,
    output logic [0:ADDR_W-1] address,
    output logic [0:0]        data_in,
    output logic              busy,
    output logic              done,
    output logic              wrap_err
);

    localparam logic [7:0]       MaxBits = 8'(MAX_BITS);
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(BYTE_W - 1);

    cfg_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [7:0]        bits_left_q, bits_left_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic              data_q, data_d;
    logic              wrap_q, wrap_d;
    logic              xfer;

    // Reset gates ready directly so upstream never sees a transfer while the writer is held.
    assign s_ready = prog_reset_n &&
                     (state_q == StIdle || state_q == StLen || state_q == StLoad);
    assign xfer    = s_valid && s_ready;

    always_comb begin
        state_d     = state_q;
        addr_cnt_d  = addr_cnt_q;
        address_d   = address_q;
        bits_left_d = bits_left_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        wrap_d      = wrap_q;

        unique case (state_q)
            StIdle: begin
                if (xfer) begin
                    addr_cnt_d = s_data[ADDR_W-1:0];
                    state_d    = StLen;
                end
            end
            StLen: begin
                if (xfer) begin
                    bits_left_d = (s_data > MaxBits) ? MaxBits : s_data;
                    state_d     = (bits_left_d == '0) ? StDone : StLoad;
                end
            end
            StLoad: begin
                if (xfer) begin
                    shift_d   = s_data;
                    bit_idx_d = '0;
                    state_d   = StSetup;
                end
            end
            StSetup: begin
                state_d = StStrobe;
            end
            StStrobe: begin
                addr_cnt_d  = addr_cnt_q + 1'b1;
                bit_idx_d   = bit_idx_q + 1'b1;
                bits_left_d = bits_left_q - 8'd1;
                // A wrap on the packet's last bit is harmless: nothing is written there.
                if ((&addr_cnt_q) && (bits_left_d != '0)) begin
                    wrap_d = 1'b1;
                end
                if (bits_left_d == '0) begin
                    state_d = StDone;
                end else if (bit_idx_q == LastIdx) begin
                    state_d = StLoad;
                end else begin
                    state_d = StSetup;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Address and data are captured on entry to SETUP so they are stable a full cycle
        // before the strobe and hold through it.
        if (state_d == StSetup) begin
            address_d = addr_cnt_d;
            data_d    = shift_d[bit_idx_d];
        end
    end

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q     <= StIdle;
            addr_cnt_q  <= '0;
            address_q   <= '0;
            bits_left_q <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_cnt_q  <= addr_cnt_d;
            address_q   <= address_d;
            bits_left_q <= bits_left_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            wrap_q      <= wrap_d;
        end
    end

    // The port is declared ascending, but address[0] must carry the LSB.
    always_comb begin
        for (int i = 0; i < int'(ADDR_W); i++) begin
            address[i] = address_q[i];
        end
    end

    assign data_in[0] = data_q;
    assign enable     = (state_q == StStrobe);
    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StDone);
    assign wrap_err   = wrap_q;

endmodule

// File: tb/tb_cb_config_writer.sv
// Self-checking bench: directed packets plus randomized streams against a packet-level model.
module tb_cb_config_writer;
    import cb_config_pkg::*;

    localparam int AW   = 7;
    localparam int AMOD = 1 << AW;

    logic          prog_clk     = 1'b0;
    logic          prog_reset_n = 1'b0;
    logic [7:0]    s_data       = '0;
    logic          s_valid      = 1'b0;
    logic          s_ready, enable, busy, done, wrap_err;
    logic [0:AW-1] address;
    logic [0:0]    data_in;

    cb_config_writer #(.ADDR_W(AW), .MAX_BITS(255)) dut (
        .prog_clk     (prog_clk),
        .prog_reset_n (prog_reset_n),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .enable       (enable),
        .address      (address),
        .data_in      (data_in),
        .busy         (busy),
        .done         (done),
        .wrap_err     (wrap_err)
    );

    always #5 prog_clk = ~prog_clk;

    int cyc = 0;
    always @(posedge prog_clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Packet-level model: every packet expands into an ordered list of (address, bit) writes.
    typedef struct {
        int addr;
        int data;
        int pkt;
        bit wrap;
    } wr_t;

    wr_t        exp_q[$];
    int         pkt_n[256];
    int         pkt_lat[256];
    int         pkt_start[256];
    int         pkt_count   = 0;
    int         done_idx    = 0;
    int         writes_seen = 0;
    bit         exp_wrap    = 1'b0;
    bit         mon_en      = 1'b0;
    int         prev_en     = 0;
    int         prev_addr   = 0;
    int         prev_data   = 0;
    int         last_wr     = 0;
    int         last_lat    = -1;
    int         obs_addr[$];
    int         obs_data[$];
    int         obs_cyc[$];
    logic [7:0] pb[$];

    function automatic int addr_val();
        int v = 0;
        for (int i = 0; i < AW; i++) begin
            if (address[i]) v = v | (1 << i);
        end
        return v;
    endfunction

    function automatic int obs_a(input int i);
        return (i < obs_addr.size()) ? obs_addr[i] : -1;
    endfunction

    function automatic int obs_d(input int i);
        return (i < obs_data.size()) ? obs_data[i] : -1;
    endfunction

    task automatic clear_obs();
        obs_addr.delete();
        obs_data.delete();
        obs_cyc.delete();
        last_lat = -1;
    endtask

    // Latency counts the byte0 cycle and the done cycle themselves.
    task automatic register_pkt(input bit clean);
        int a0;
        int n;
        a0 = int'(pb[0]) % AMOD;
        n  = int'(pb[1]);
        for (int k = 0; k < n; k++) begin
            wr_t        w;
            logic [7:0] by;
            by     = pb[2 + k / 8];
            w.addr = (a0 + k) % AMOD;
            w.data = int'(by[k % 8]);
            w.pkt  = pkt_count;
            w.wrap = (w.addr == AMOD - 1) && (k != n - 1);
            exp_q.push_back(w);
        end
        pkt_n[pkt_count]   = n;
        pkt_lat[pkt_count] = clean ? int'(HDR_BYTES) + (n + 7) / 8 + 2 * n + 1 : -1;
        pkt_count++;
    endtask

    always @(negedge prog_clk) begin
        int  a;
        wr_t e;
        if (mon_en) begin
            a = addr_val();
            chk("wrap_err", wrap_err, exp_wrap);
            if (enable) begin
                chk("busy_at_enable", busy, 1);
                chk("enable_back_to_back", prev_en, 0);
                chk("setup_addr_stable", a, prev_addr);
                chk("setup_data_stable", data_in[0], prev_data);
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_addr", a, e.addr);
                    chk("write_data", data_in[0], e.data);
                    chk("write_packet", e.pkt, done_idx);
                    if (e.wrap) exp_wrap = 1'b1;
                end
                writes_seen++;
                last_wr = a;
                obs_addr.push_back(a);
                obs_data.push_back(int'(data_in[0]));
                obs_cyc.push_back(cyc);
            end
            if (done) begin
                chk("busy_at_done", busy, 1);
                if (done_idx >= pkt_count) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    chk("writes_per_packet", writes_seen, pkt_n[done_idx]);
                    if (pkt_n[done_idx] > 0) chk("addr_held_at_done", a, last_wr);
                    last_lat = cyc - pkt_start[done_idx] + 2;
                    if (pkt_lat[done_idx] >= 0) chk("packet_latency", last_lat, pkt_lat[done_idx]);
                    done_idx++;
                end
                writes_seen = 0;
            end
            prev_en   = int'(enable);
            prev_addr = a;
            prev_data = int'(data_in[0]);
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (!s_ready && t < 600) begin
            @(negedge prog_clk);
            t++;
        end
        if (!s_ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic send_byte(input logic [7:0] b, output int edge_no);
        int t = 0;
        s_valid = 1'b1;
        s_data  = b;
        while (!s_ready && t < 600) begin
            @(negedge prog_clk);
            t++;
        end
        if (!s_ready) chk("send_timeout", 0, 1);
        edge_no = cyc + 1;
        @(negedge prog_clk);
        s_valid = 1'b0;
        s_data  = 8'($urandom);
    endtask

    // A gap holds s_valid low for that many cycles after the writer becomes ready.
    task automatic send_packet(input int gap_at, input int gap_len, input bit rnd);
        int g[$];
        bit clean = 1'b1;
        int e;
        int p;
        for (int i = 0; i < pb.size(); i++) begin
            int x;
            x = (i == gap_at) ? gap_len : 0;
            if (rnd && $urandom_range(0, 3) == 0) x = int'($urandom_range(1, 4));
            g.push_back(x);
            if (x != 0) clean = 1'b0;
        end
        p = pkt_count;
        register_pkt(clean);
        for (int i = 0; i < pb.size(); i++) begin
            if (g[i] > 0) begin
                wait_ready();
                repeat (g[i]) @(negedge prog_clk);
            end
            send_byte(pb[i], e);
            if (i == 0) pkt_start[p] = e;
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (done_idx < pkt_count && t < 3000) begin
            @(negedge prog_clk);
            t++;
        end
        chk("packet_completion", done_idx, pkt_count);
        @(negedge prog_clk);
        chk("busy_after_done", busy, 0);
        chk("model_queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int n;
        int a;

        // Reset state, with s_valid high to show ready is gated by reset.
        s_valid = 1'b1;
        s_data  = 8'hA5;
        #2;
        chk("rst_enable", enable, 0);
        chk("rst_address", addr_val(), 0);
        chk("rst_data_in", data_in[0], 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wrap_err", wrap_err, 0);
        chk("rst_s_ready", s_ready, 0);
        s_valid = 1'b0;
        repeat (2) @(negedge prog_clk);
        prog_reset_n = 1'b1;
        @(negedge prog_clk);
        mon_en = 1'b1;
        chk("idle_s_ready", s_ready, 1);

        // Basic packet.
        clear_obs();
        pb = {8'h05, 8'h03, 8'h05};
        send_packet(-1, 0, 1'b0);
        wait_idle();
        chk("basic_count", obs_addr.size(), 3);
        chk("basic_a0", obs_a(0), 5);
        chk("basic_a1", obs_a(1), 6);
        chk("basic_a2", obs_a(2), 7);
        chk("basic_d0", obs_d(0), 1);
        chk("basic_d1", obs_d(1), 0);
        chk("basic_d2", obs_d(2), 1);
        chk("basic_latency", last_lat, 10);

        // Byte boundary with a 4-cycle upstream stall before the second data byte.
        clear_obs();
        pb = {8'h30, 8'h0A, 8'hFF, 8'h02};
        send_packet(3, 4, 1'b0);
        wait_idle();
        chk("stall_count", obs_addr.size(), 10);
        for (int k = 0; k < 10; k++) begin
            chk("stall_addr", obs_a(k), 8'h30 + k);
            chk("stall_data", obs_d(k), (k < 8) ? 1 : ((k == 8) ? 0 : 1));
        end
        if (obs_cyc.size() >= 9) chk("stall_gap_cycles", obs_cyc[8] - obs_cyc[7], 7);
        else chk("stall_gap_cycles", -1, 7);

        // Zero length.
        clear_obs();
        pb = {8'h10, 8'h00};
        send_packet(-1, 0, 1'b0);
        wait_idle();
        chk("zero_count", obs_addr.size(), 0);
        chk("zero_latency", last_lat, 3);

        // Upper address bits ignored; a lone write at the top address does not flag a wrap.
        clear_obs();
        pb = {8'hFF, 8'h01, 8'h01};
        send_packet(-1, 0, 1'b0);
        wait_idle();
        chk("mask_addr", obs_a(0), 127);
        chk("mask_data", obs_d(0), 1);
        chk("mask_no_wrap", wrap_err, 0);

        clear_obs();
        pb = {8'h7F, 8'h01, 8'h01};
        send_packet(-1, 0, 1'b0);
        wait_idle();
        chk("last_bit_addr", obs_a(0), 127);
        chk("last_bit_no_wrap", wrap_err, 0);

        // Wrap inside a packet; the final data byte's high bits are ignored.
        clear_obs();
        pb = {8'h7E, 8'h04, 8'hFF};
        send_packet(-1, 0, 1'b0);
        wait_idle();
        chk("wrap_a0", obs_a(0), 126);
        chk("wrap_a1", obs_a(1), 127);
        chk("wrap_a2", obs_a(2), 0);
        chk("wrap_a3", obs_a(3), 1);
        chk("wrap_count", obs_addr.size(), 4);
        chk("wrap_sticky", wrap_err, 1);

        // Randomized streams, sent back to back with occasional stalls.
        for (int p = 0; p < 30; p++) begin
            n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                            : int'($urandom_range(0, 20));
            a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(120, 255))
                                            : int'($urandom_range(0, 255));
            pb = {};
            pb.push_back(8'(a));
            pb.push_back(8'(n));
            for (int b = 0; b < (n + 7) / 8; b++) pb.push_back(8'($urandom));
            send_packet(-1, 0, (p % 2) == 1);
        end
        wait_idle();

        // Reset in the middle of a strobe.
        pb = {8'h20, 8'h05, 8'h1F};
        send_packet(-1, 0, 1'b0);
        t = 0;
        while (!enable && t < 50) begin
            @(negedge prog_clk);
            t++;
        end
        chk("strobe_reached", enable, 1);
        mon_en = 1'b0;
        #1 prog_reset_n = 1'b0;
        #1;
        chk("abort_enable", enable, 0);
        chk("abort_address", addr_val(), 0);
        chk("abort_data_in", data_in[0], 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_wrap_err", wrap_err, 0);
        chk("abort_s_ready", s_ready, 0);
        exp_q.delete();
        done_idx    = pkt_count;
        writes_seen = 0;
        exp_wrap    = 1'b0;
        prev_en     = 0;
        prev_addr   = 0;
        prev_data   = 0;
        @(negedge prog_clk);
        prog_reset_n = 1'b1;
        @(negedge prog_clk);
        mon_en = 1'b1;

        clear_obs();
        pb = {8'h00, 8'h01, 8'h01};
        send_packet(-1, 0, 1'b0);
        wait_idle();
        chk("post_reset_count", obs_addr.size(), 1);
        chk("post_reset_addr", obs_a(0), 0);
        chk("post_reset_data", obs_d(0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
